// File: rtl/emc_pht_capture.sv
// PHT period capture: synchronizes and glitch-filters the pin, then measures the
// prescaled tick count between consecutive active edges with sticky status flags.
module emc_pht_capture #(
  parameter int unsigned FILT_LEN = 3
) (
  input  logic        pcap_clock_i,
  input  logic        pcap_reset_i,
  input  logic        pcap_pht_i,
  input  logic        pcap_en_i,
  input  logic        pcap_edge_sel_i,
  input  logic [1:0]  pcap_presc_i,
  input  logic        pcap_rd_i,
  output logic [15:0] pcap_period_o,
  output logic        pcap_valid_o,
  output logic        pcap_ovf_o,
  output logic        pcap_lost_o,
  output logic        pcap_irq_o,
  output logic        pcap_pht_sync_o
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned PSC_W  = 6;
  localparam int unsigned FCNT_W = 4;

  typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_MEAS} state_t;

  state_t              r_state;
  logic                r_sync1;
  logic                r_sync2;
  logic                r_filt;
  logic                r_filt_d;
  logic [FCNT_W-1:0]   r_fcnt;
  logic                r_cfg_sel;
  logic [1:0]          r_cfg_presc;
  logic [PSC_W-1:0]    r_psc;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    r_period;
  logic                r_valid;
  logic                r_ovf;
  logic                r_lost;
  logic                r_irq;

  logic [PSC_W-1:0]    w_div_m1;
  logic                w_edge;
  logic                w_tick;
  logic                w_meas;
  logic                w_ovf_evt;
  logic                w_cap_evt;

  // Two-flop synchronizer followed by a run-length filter on the synchronized level.
  always_ff @(posedge pcap_clock_i or negedge pcap_reset_i) begin
    if (!pcap_reset_i) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_filt   <= 1'b0;
      r_filt_d <= 1'b0;
      r_fcnt   <= '0;
    end else begin
      r_sync1  <= pcap_pht_i;
      r_sync2  <= r_sync1;
      r_filt_d <= r_filt;
      if (r_sync2 != r_filt) begin
        if (r_fcnt == FCNT_W'(FILT_LEN - 1)) begin
          r_filt <= r_sync2;
          r_fcnt <= '0;
        end else begin
          r_fcnt <= r_fcnt + FCNT_W'(1);
        end
      end else begin
        r_fcnt <= '0;
      end
    end
  end

  always_comb begin
    w_div_m1 = PSC_W'(63);
    case (r_cfg_presc)
      2'd0:    w_div_m1 = PSC_W'(0);
      2'd1:    w_div_m1 = PSC_W'(3);
      2'd2:    w_div_m1 = PSC_W'(15);
      default: w_div_m1 = PSC_W'(63);
    endcase
  end

  // Active edge is visible in the same cycle the filtered level changes.
  assign w_edge    = (r_filt != r_filt_d) && (r_filt != r_cfg_sel);
  assign w_tick    = (r_psc == w_div_m1);
  assign w_meas    = pcap_en_i && (r_state == ST_MEAS);
  assign w_ovf_evt = w_meas && w_tick && (r_cnt == {CNT_W{1'b1}});
  assign w_cap_evt = w_meas && w_edge && !w_ovf_evt;

  // Measurement FSM, counters and CPU-visible status.
  always_ff @(posedge pcap_clock_i or negedge pcap_reset_i) begin
    if (!pcap_reset_i) begin
      r_state     <= ST_IDLE;
      r_cfg_sel   <= 1'b0;
      r_cfg_presc <= 2'd0;
      r_psc       <= '0;
      r_cnt       <= '0;
      r_period    <= '0;
      r_valid     <= 1'b0;
      r_ovf       <= 1'b0;
      r_lost      <= 1'b0;
      r_irq       <= 1'b0;
    end else begin
      r_irq <= w_cap_evt | w_ovf_evt;

      // A read coincident with a capture keeps valid set and leaves lost as is.
      if (w_cap_evt) begin
        r_period <= r_cnt + CNT_W'(w_tick);
        r_valid  <= 1'b1;
        if (r_valid && !pcap_rd_i) begin
          r_lost <= 1'b1;
        end
      end else if (pcap_rd_i) begin
        r_valid <= 1'b0;
        r_lost  <= 1'b0;
      end

      if (w_ovf_evt) begin
        r_ovf <= 1'b1;
      end else if (pcap_rd_i) begin
        r_ovf <= 1'b0;
      end

      if (!pcap_en_i) begin
        r_state <= ST_IDLE;
        r_psc   <= '0;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state     <= ST_ARM;
            r_cfg_sel   <= pcap_edge_sel_i;
            r_cfg_presc <= pcap_presc_i;
            r_psc       <= '0;
            r_cnt       <= '0;
          end
          ST_ARM: begin
            if (w_edge) begin
              r_state <= ST_MEAS;
            end
            r_psc <= '0;
            r_cnt <= '0;
          end
          ST_MEAS: begin
            if (w_ovf_evt) begin
              r_state <= ST_ARM;
              r_psc   <= '0;
              r_cnt   <= '0;
            end else if (w_edge) begin
              r_psc <= '0;
              r_cnt <= '0;
            end else if (w_tick) begin
              r_psc <= '0;
              r_cnt <= r_cnt + CNT_W'(1);
            end else begin
              r_psc <= r_psc + PSC_W'(1);
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_psc   <= '0;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign pcap_period_o   = r_period;
  assign pcap_valid_o    = r_valid;
  assign pcap_ovf_o      = r_ovf;
  assign pcap_lost_o     = r_lost;
  assign pcap_irq_o      = r_irq;
  assign pcap_pht_sync_o = r_filt;

endmodule

// File: tb/tb_emc_pht_capture.sv
// Directed bench for emc_pht_capture: filter latency, period capture, prescaling,
// glitch rejection, overflow, overrun/read flag handling and mid-measurement reset.
module tb_emc_pht_capture;

  logic        clk;
  logic        rst_n;
  logic        pht;
  logic        en;
  logic        sel;
  logic [1:0]  presc;
  logic        rd;
  logic [15:0] period;
  logic        valid;
  logic        ovf;
  logic        lost;
  logic        irq;
  logic        sync_o;

  int n_checks;
  int n_fail;
  int irq_cnt;
  int irq_base;
  int hi_cnt;

  emc_pht_capture #(.FILT_LEN(3)) dut (
    .pcap_clock_i    (clk),
    .pcap_reset_i    (rst_n),
    .pcap_pht_i      (pht),
    .pcap_en_i       (en),
    .pcap_edge_sel_i (sel),
    .pcap_presc_i    (presc),
    .pcap_rd_i       (rd),
    .pcap_period_o   (period),
    .pcap_valid_o    (valid),
    .pcap_ovf_o      (ovf),
    .pcap_lost_o     (lost),
    .pcap_irq_o      (irq),
    .pcap_pht_sync_o (sync_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial irq_cnt = 0;
  always @(negedge clk) begin
    if (irq) irq_cnt++;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One pin period of d cycles starting with a rise; optional read strobe in cycle rd_at.
  task automatic pulse(input int d, input int rd_at);
    pht = 1'b1;
    for (int k = 0; k < d; k++) begin
      rd = (k == rd_at);
      if (k == d / 2) pht = 1'b0;
      step(1);
    end
    rd = 1'b0;
  endtask

  task automatic do_rd();
    rd = 1'b1;
    step(1);
    rd = 1'b0;
  endtask

  task automatic reconfig(input logic s, input logic [1:0] p);
    en = 1'b0;
    step(2);
    sel   = s;
    presc = p;
    en    = 1'b1;
    step(2);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    pht   = 1'b1;
    en    = 1'b0;
    sel   = 1'b0;
    presc = 2'd0;
    rd    = 1'b0;
    step(3);

    // Reset state with pin held high
    check_val("rst_period", 32'(period), 32'd0);
    check_val("rst_valid",  32'(valid),  32'd0);
    check_val("rst_ovf",    32'(ovf),    32'd0);
    check_val("rst_lost",   32'(lost),   32'd0);
    check_val("rst_irq",    32'(irq),    32'd0);
    check_val("rst_sync",   32'(sync_o), 32'd0);

    rst_n = 1'b1;
    step(4);
    check_val("sync_lat4", 32'(sync_o), 32'd0);
    step(1);
    check_val("sync_lat5", 32'(sync_o), 32'd1);

    pht = 1'b0;
    step(8);
    check_val("sync_low", 32'(sync_o), 32'd0);

    // presc /1, rising edges every 100 cycles
    en = 1'b1;
    step(2);
    irq_base = irq_cnt;
    pulse(100, -1);
    check_val("arm_no_valid", 32'(valid), 32'd0);
    check_val("arm_no_irq",   32'(irq_cnt - irq_base), 32'd0);
    pulse(100, -1);
    check_val("p100_period", 32'(period), 32'd100);
    check_val("p100_valid",  32'(valid),  32'd1);
    check_val("p100_irq",    32'(irq_cnt - irq_base), 32'd1);
    pulse(100, 2);
    check_val("p100b_period", 32'(period), 32'd100);
    check_val("p100b_valid",  32'(valid),  32'd1);
    check_val("p100b_lost",   32'(lost),   32'd0);
    check_val("p100b_irq",    32'(irq_cnt - irq_base), 32'd2);

    // presc /16, 1000-cycle spacing, rising then falling
    do_rd();
    reconfig(1'b0, 2'd2);
    pulse(1000, -1);
    check_val("p16r_arm", 32'(valid), 32'd0);
    pulse(1000, -1);
    check_val("p16r_period", 32'(period), 32'd62);
    check_val("p16r_valid",  32'(valid),  32'd1);
    do_rd();
    reconfig(1'b1, 2'd2);
    irq_base = irq_cnt;
    pulse(1000, -1);
    check_val("p16f_arm", 32'(valid), 32'd0);
    pulse(1000, -1);
    check_val("p16f_period", 32'(period), 32'd62);
    check_val("p16f_valid",  32'(valid),  32'd1);
    check_val("p16f_irq",    32'(irq_cnt - irq_base), 32'd1);

    // Glitch rejection: 2-cycle pulse ignored, 3-cycle pulses pass 40 cycles apart
    do_rd();
    reconfig(1'b0, 2'd0);
    pht = 1'b1;
    step(2);
    pht = 1'b0;
    hi_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      step(1);
      if (sync_o) hi_cnt++;
    end
    check_val("glitch2_sync", 32'(hi_cnt), 32'd0);
    hi_cnt = 0;
    for (int k = 0; k < 80; k++) begin
      pht = (k < 3) || (k >= 40 && k < 43);
      step(1);
      if (sync_o) hi_cnt++;
    end
    check_val("pulse3_sync",   32'(hi_cnt), 32'd6);
    check_val("pulse3_period", 32'(period), 32'd40);
    check_val("pulse3_valid",  32'(valid),  32'd1);

    // Overflow: arming edge then no edge for 65536 ticks
    do_rd();
    reconfig(1'b0, 2'd0);
    pulse(100, -1);
    step(65441);
    check_val("ovf_before", 32'(ovf), 32'd0);
    check_val("ovf_irq_before", 32'(irq), 32'd0);
    step(1);
    check_val("ovf_set",   32'(ovf),   32'd1);
    check_val("ovf_irq",   32'(irq),   32'd1);
    check_val("ovf_valid", 32'(valid), 32'd0);
    step(1);
    check_val("ovf_irq_end", 32'(irq), 32'd0);
    pulse(100, -1);
    check_val("ovf_rearm_valid", 32'(valid), 32'd0);
    pulse(100, -1);
    check_val("ovf_cap_period", 32'(period), 32'd100);
    check_val("ovf_cap_valid",  32'(valid),  32'd1);
    check_val("ovf_sticky",     32'(ovf),    32'd1);

    // Overrun and read interaction
    pulse(80, 2);
    check_val("rd_ovf_clr",  32'(ovf),    32'd0);
    check_val("cap1_period", 32'(period), 32'd100);
    check_val("cap1_lost",   32'(lost),   32'd0);
    pulse(60, -1);
    check_val("cap2_period", 32'(period), 32'd80);
    check_val("cap2_lost",   32'(lost),   32'd1);
    pulse(70, 5);
    check_val("cap3_period", 32'(period), 32'd60);
    check_val("cap3_valid",  32'(valid),  32'd1);
    check_val("cap3_lost",   32'(lost),   32'd1);
    do_rd();
    check_val("rd_valid", 32'(valid), 32'd0);
    check_val("rd_lost",  32'(lost),  32'd0);
    check_val("rd_ovf",   32'(ovf),   32'd0);

    // Reset in the middle of a measurement
    step(20);
    rst_n = 1'b0;
    step(1);
    check_val("mrst_period", 32'(period), 32'd0);
    check_val("mrst_valid",  32'(valid),  32'd0);
    rst_n = 1'b1;
    step(2);
    pulse(100, -1);
    check_val("mrst_arm_valid", 32'(valid), 32'd0);
    pulse(100, -1);
    check_val("mrst_period2", 32'(period), 32'd100);
    check_val("mrst_valid2",  32'(valid),  32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/emc_pht_capture.md
EMC_PHT_CAPTURE -- requirements
Module: emc_pht_capture

Interface
REQ-001 SHALL have parameter FILT_LEN, default 3: number of consecutive equal synchronized samples needed to change the filtered level (range 1..15).
REQ-002 SHALL have port pcap_clock_i, input, 1 bit: the single clock; all flops are rising-edge triggered.
REQ-003 SHALL have port pcap_reset_i, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port pcap_pht_i, input, 1 bit: raw asynchronous PHT pin, sourced from top_pht_i.
REQ-005 SHALL have port pcap_en_i, input, 1 bit: measurement enable.
REQ-006 SHALL have port pcap_edge_sel_i, input, 1 bit: active edge; 0 = rising, 1 = falling.
REQ-007 SHALL have port pcap_presc_i, input, 2 bits: tick divider; 0 = /1, 1 = /4, 2 = /16, 3 = /64.
REQ-008 SHALL have port pcap_rd_i, input, 1 bit: one-cycle read strobe from the CPU side.
REQ-009 SHALL have port pcap_period_o, output, 16 bits: last captured period, in ticks.
REQ-010 SHALL have port pcap_valid_o, output, 1 bit: unread capture is present.
REQ-011 SHALL have port pcap_ovf_o, output, 1 bit: sticky period-overflow flag (missing edge).
REQ-012 SHALL have port pcap_lost_o, output, 1 bit: sticky overrun flag (a capture overwrote an unread value).
REQ-013 SHALL have port pcap_irq_o, output, 1 bit: one-cycle interrupt pulse.
REQ-014 SHALL have port pcap_pht_sync_o, output, 1 bit: filtered pin level.

Function
REQ-015 Synchronizer: pcap_pht_i SHALL pass through a 2-flop synchronizer.
REQ-016 Filter: the filtered level SHALL change only after FILT_LEN consecutive synchronized samples differ from it.
REQ-017 Filter latency: a clean pin transition SHALL reach pcap_pht_sync_o exactly 2+FILT_LEN cycles later; shorter pulses SHALL be ignored.
REQ-018 Edge detect: an active edge SHALL be a filtered-level transition matching pcap_edge_sel_i, flagged in the same cycle pcap_pht_sync_o changes.
REQ-019 FSM states: IDLE, ARM, MEAS.
REQ-020 FSM transitions: any state -> IDLE when pcap_en_i=0; IDLE -> ARM when pcap_en_i=1; ARM -> MEAS on an active edge, with no capture; MEAS -> ARM on overflow.
REQ-021 Config latch: pcap_edge_sel_i and pcap_presc_i SHALL be latched on the IDLE->ARM transition and ignored otherwise.
REQ-022 Prescaler: a 6-bit psc SHALL run in MEAS; tick = (psc == div-1); psc wraps to 0 on tick; psc <= 0 on an active edge and outside MEAS.
REQ-023 Counter: a 16-bit cnt SHALL increment on each tick in a MEAS non-edge cycle; cnt <= 0 on an active edge and outside MEAS.
REQ-024 Capture: on an active edge in MEAS, pcap_period_o SHALL load cnt+tick; for edges D cycles apart this equals floor(D/div).
REQ-025 Overflow: tick with cnt==0xFFFF, in an edge or non-edge cycle, SHALL set ovf, perform no capture, clear cnt/psc and enter ARM.
REQ-026 Valid/lost: a capture SHALL set valid; if valid=1 and pcap_rd_i=0 in that cycle, lost SHALL also set and pcap_period_o SHALL be overwritten.
REQ-027 Read: pcap_rd_i SHALL clear valid, ovf and lost next cycle; rd coincident with a capture leaves valid=1, lost unchanged, ovf cleared.
REQ-028 Interrupt: pcap_irq_o SHALL pulse for exactly one cycle, one cycle after a capture or overflow event.
REQ-029 Disable: pcap_en_i=0 SHALL clear cnt/psc and hold period/valid/ovf/lost; the synchronizer and filter keep running.

Reset
REQ-030 On pcap_reset_i=0, all flops SHALL clear asynchronously: state=IDLE, outputs 0, sync/filter state 0, cnt/psc 0, latched config 0.
REQ-031 Reset mid-measurement SHALL discard the partial count; after release, first edge re-arms with no capture.
REQ-032 Reset SHALL deassert synchronously via the existing top-level reset synchronizer; no internal reset synchronizer.

Verification
REQ-033 Reset with pin=1 -> all outputs 0, pcap_pht_sync_o rises 5 cycles after release (FILT_LEN=3).
REQ-034 en=1, presc=0, rising edges every 100 cycles -> first edge no capture; then period=100, valid=1, irq pulses once per edge.
REQ-035 presc=2, edges 1000 cycles apart -> period=62; edge_sel=1 gives identical result on falling edges.
REQ-036 2-cycle high glitch -> no edge, sync stays 0; 3-cycle pulse -> sync toggles, edge detected.
REQ-037 presc=0, no edge for 65536 ticks after arming -> ovf=1, irq pulse, ARM; next edge no capture, following edge captures correctly.
REQ-038 Two captures without rd -> lost=1, period=second value; rd coincident with third capture -> valid=1, lost=1; next rd clears all flags.
